// File: rtl/pipe_perf_monitor.sv
// rtl/pipe_perf_monitor.sv - pipeline performance monitor: run-cycle and hazard-event counters with cycle limit and read port
// Optional PIPE_PERF_MON_SATURATE_EN: counters saturate at all-ones instead of wrapping.
module pipe_perf_monitor #(
    parameter int NUM_EVT   = 2,
    parameter int CNT_W     = 32,
    parameter int CYC_LIMIT = 64,
    parameter int SEL_W     = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               clear_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic               rd_req_i,
    input  logic [SEL_W-1:0]   rd_sel_i,
    output logic               rd_valid_o,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic               rd_err_o,
    output logic [CNT_W-1:0]   cycle_o,
    output logic [NUM_EVT:0]   ovf_o,
    output logic               done_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(CYC_LIMIT);

    // Slot 0 is the cycle counter, slot k+1 is event channel k.
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q [NUM_EVT+1];
    logic [NUM_EVT:0] ovf_q;
    logic             done_q;
    logic             rd_valid_q;
    logic             rd_err_q;
    logic [CNT_W-1:0] rd_data_q;

    logic [CNT_W-1:0] cnt_d [NUM_EVT+1];
    logic [NUM_EVT:0] cnt_max;
    logic [NUM_EVT:0] cnt_en;
    logic             limit_hit;
    logic [CNT_W-1:0] sel_val;
    logic             sel_err;

    always_comb begin
        cnt_en = '0;
        if (state_q == ST_RUN && start_i) begin
            cnt_en[0] = 1'b1;
            for (int k = 0; k < NUM_EVT; k++) begin
                cnt_en[k+1] = evt_i[k];
            end
        end
        for (int i = 0; i <= NUM_EVT; i++) begin
            cnt_max[i] = &cnt_q[i];
`ifdef PIPE_PERF_MON_SATURATE_EN
            cnt_d[i] = cnt_max[i] ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
`else
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
`endif
        end
        limit_hit = (CYC_LIMIT != 0) && (cnt_d[0] == LIMIT);
    end

    // Read mux sees the registered values, so a read returns pre-update data.
    always_comb begin
        sel_val = '0;
        sel_err = (int'(rd_sel_i) > NUM_EVT);
        for (int i = 0; i <= NUM_EVT; i++) begin
            if (int'(rd_sel_i) == i) begin
                sel_val = cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            for (int i = 0; i <= NUM_EVT; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q      <= '0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_req_i;
            rd_err_q   <= rd_req_i & sel_err;
            if (rd_req_i) begin
                rd_data_q <= sel_err ? '0 : sel_val;
            end

            if (clear_i) begin
                state_q <= ST_IDLE;
                for (int i = 0; i <= NUM_EVT; i++) begin
                    cnt_q[i] <= '0;
                end
                ovf_q  <= '0;
                done_q <= 1'b0;
            end else begin
                for (int i = 0; i <= NUM_EVT; i++) begin
                    if (cnt_en[i]) begin
                        cnt_q[i] <= cnt_d[i];
                        if (cnt_max[i]) begin
                            ovf_q[i] <= 1'b1;
                        end
                    end
                end
                case (state_q)
                    ST_IDLE: begin
                        if (start_i) begin
                            state_q <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (!start_i) begin
                            state_q <= ST_IDLE;
                        end else if (limit_hit) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_DONE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_err_o   = rd_err_q;
    assign rd_data_o  = rd_data_q;
    assign cycle_o    = cnt_q[0];
    assign ovf_o      = ovf_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// tb/tb_pipe_perf_monitor.sv - scoreboard bench for pipe_perf_monitor (default and 8-bit no-limit instances)
module tb_pipe_perf_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, start_a, clear_a, rd_req_a;
    logic [1:0]  evt_a, sel_a;
    logic        rd_valid_a, rd_err_a, done_a;
    logic [31:0] rd_data_a, cycle_a;
    logic [2:0]  ovf_a;

    logic        rst_b, start_b, clear_b, rd_req_b;
    logic [1:0]  evt_b, sel_b;
    logic        rd_valid_b, rd_err_b, done_b;
    logic [7:0]  rd_data_b, cycle_b;
    logic [2:0]  ovf_b;

    pipe_perf_monitor dut_a (
        .clk_i(clk), .rst_i(rst_a), .start_i(start_a), .clear_i(clear_a),
        .evt_i(evt_a), .rd_req_i(rd_req_a), .rd_sel_i(sel_a),
        .rd_valid_o(rd_valid_a), .rd_data_o(rd_data_a), .rd_err_o(rd_err_a),
        .cycle_o(cycle_a), .ovf_o(ovf_a), .done_o(done_a)
    );

    pipe_perf_monitor #(.NUM_EVT(2), .CNT_W(8), .CYC_LIMIT(0), .SEL_W(2)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .start_i(start_b), .clear_i(clear_b),
        .evt_i(evt_b), .rd_req_i(rd_req_b), .rd_sel_i(sel_b),
        .rd_valid_o(rd_valid_b), .rd_data_o(rd_data_b), .rd_err_o(rd_err_b),
        .cycle_o(cycle_b), .ovf_o(ovf_b), .done_o(done_b)
    );

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_a[$];
    logic [8:0]  exp_b[$];

`ifdef PIPE_PERF_MON_SATURATE_EN
    localparam logic [7:0] OVF_VAL = 8'd255;
`else
    localparam logic [7:0] OVF_VAL = 8'd4;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops the expected read result whenever a DUT presents rd_valid.
    always @(negedge clk) begin
        logic [32:0] ea;
        logic [8:0]  eb;
        if (rd_valid_a) begin
            if (exp_a.size() == 0) chk("rd_a_unexpected", 64'd1, 64'd0);
            else begin
                ea = exp_a.pop_front();
                chk("rd_a_data", 64'(rd_data_a), 64'(ea[31:0]));
                chk("rd_a_err", 64'(rd_err_a), 64'(ea[32]));
            end
        end else if (rd_err_a) chk("rd_a_err_no_valid", 64'(rd_err_a), 64'd0);
        if (rd_valid_b) begin
            if (exp_b.size() == 0) chk("rd_b_unexpected", 64'd1, 64'd0);
            else begin
                eb = exp_b.pop_front();
                chk("rd_b_data", 64'(rd_data_b), 64'(eb[7:0]));
                chk("rd_b_err", 64'(rd_err_b), 64'(eb[8]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        rst_a = 1; start_a = 0; clear_a = 0; rd_req_a = 0; evt_a = 0; sel_a = 0;
        rst_b = 1; start_b = 0; clear_b = 0; rd_req_b = 0; evt_b = 0; sel_b = 0;
        step(2);
        rst_a = 0; rst_b = 0;
        chk("rst_cycle", 64'(cycle_a), 64'd0);
        chk("rst_ovf", 64'(ovf_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid_a), 64'd0);
        chk("rst_rd_data", 64'(rd_data_a), 64'd0);
        chk("rst_rd_err", 64'(rd_err_a), 64'd0);

        // Limit run: stall every third RUN cycle, 64 run cycles.
        start_a = 1;
        step(1);
        chk("run_entry_cycle", 64'(cycle_a), 64'd0);
        for (int i = 0; i < 64; i++) begin
            evt_a = (i % 3 == 0) ? 2'b01 : 2'b00;
            step(1);
            if (i == 62) begin
                chk("pre_limit_cycle", 64'(cycle_a), 64'd63);
                chk("pre_limit_done", 64'(done_a), 64'd0);
            end
        end
        chk("limit_cycle", 64'(cycle_a), 64'd64);
        chk("limit_done", 64'(done_a), 64'd1);
        evt_a = 2'b11;
        rd_req_a = 1;
        sel_a = 2'd1; exp_a.push_back({1'b0, 32'd22}); step(1);
        sel_a = 2'd2; exp_a.push_back({1'b0, 32'd0});  step(1);
        sel_a = 2'd3; exp_a.push_back({1'b1, 32'd0});  step(1);
        sel_a = 2'd0; exp_a.push_back({1'b0, 32'd64}); step(1);
        rd_req_a = 0;
        step(10);
        chk("done_frozen_cycle", 64'(cycle_a), 64'd64);
        chk("done_frozen_done", 64'(done_a), 64'd1);
        rd_req_a = 1; sel_a = 2'd1; exp_a.push_back({1'b0, 32'd22}); step(1);
        rd_req_a = 0; evt_a = 2'b00;

        // Clear in DONE with start held and a same-cycle read.
        clear_a = 1; rd_req_a = 1; sel_a = 2'd1; exp_a.push_back({1'b0, 32'd22});
        step(1);
        clear_a = 0; rd_req_a = 0;
        chk("clear_cycle", 64'(cycle_a), 64'd0);
        chk("clear_done", 64'(done_a), 64'd0);
        chk("clear_ovf", 64'(ovf_a), 64'd0);
        step(1);
        chk("clear_idle_to_run", 64'(cycle_a), 64'd0);
        step(1);
        chk("clear_first_count", 64'(cycle_a), 64'd1);
        rd_req_a = 1; sel_a = 2'd1; exp_a.push_back({1'b0, 32'd0}); step(1);
        rd_req_a = 0;

        // Pause: 10 RUN cycles, 5 paused with events, resume for 5 counting cycles.
        rst_a = 1; step(1); rst_a = 0;
        start_a = 1; evt_a = 2'b00; step(1);
        evt_a = 2'b10;
        for (int i = 0; i < 10; i++) begin
            if (i == 7) begin
                rd_req_a = 1; sel_a = 2'd0; exp_a.push_back({1'b0, 32'd7});
            end
            step(1);
            if (i == 7) begin
                chk("rd_edge_cycle", 64'(cycle_a), 64'd8);
                chk("rd_edge_valid", 64'(rd_valid_a), 64'd1);
                rd_req_a = 0;
            end
            if (i == 8) begin
                chk("rd_valid_drop", 64'(rd_valid_a), 64'd0);
                chk("rd_data_hold", 64'(rd_data_a), 64'd7);
            end
        end
        start_a = 0; evt_a = 2'b11; step(5);
        chk("pause_cycle", 64'(cycle_a), 64'd10);
        start_a = 1; evt_a = 2'b01; step(6);
        chk("resume_cycle", 64'(cycle_a), 64'd15);
        evt_a = 2'b00; rd_req_a = 1;
        sel_a = 2'd1; exp_a.push_back({1'b0, 32'd5});  step(1);
        sel_a = 2'd2; exp_a.push_back({1'b0, 32'd10}); step(1);
        sel_a = 2'd0; exp_a.push_back({1'b0, 32'd17}); step(1);
        rd_req_a = 0;

        // Reset mid-RUN with a read pending: request is dropped.
        rst_a = 1; rd_req_a = 1; sel_a = 2'd0; step(1);
        rst_a = 0; rd_req_a = 0;
        chk("rst_run_valid", 64'(rd_valid_a), 64'd0);
        chk("rst_run_data", 64'(rd_data_a), 64'd0);
        chk("rst_run_cycle", 64'(cycle_a), 64'd0);
        chk("rst_run_done", 64'(done_a), 64'd0);

        // Overflow on the 8-bit, unlimited instance.
        start_b = 1; evt_b = 2'b01; step(1);
        for (int i = 0; i < 260; i++) begin
            step(1);
            if (i == 254) chk("b_pre_ovf", 64'(ovf_b), 64'd0);
            if (i == 255) chk("b_ovf_set", 64'(ovf_b), 64'd3);
        end
        start_b = 0; evt_b = 2'b00; rd_req_b = 1;
        sel_b = 2'd1; exp_b.push_back({1'b0, OVF_VAL}); step(1);
        sel_b = 2'd2; exp_b.push_back({1'b0, 8'd0});    step(1);
        rd_req_b = 0;
        chk("b_cycle", 64'(cycle_b), 64'(OVF_VAL));
        chk("b_ovf_sticky", 64'(ovf_b), 64'd3);
        chk("b_done", 64'(done_b), 64'd0);

        step(3);
        chk("a_queue_drained", 64'(exp_a.size()), 64'd0);
        chk("b_queue_drained", 64'(exp_b.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_perf_monitor.md
# pipe_perf_monitor

- Parametrised pipeline performance-monitor unit for the five-stage core.
- Counts run cycles and up to NUM_EVT single-bit hazard events (stall, flush, and others wired by the integrator).
- Requests a halt after a programmable cycle limit.
- Returns counter values through a one-cycle read handshake, replacing ad-hoc stall/flush tallies in simulation with a synthesizable block.

## Interface
Parameters:
- NUM_EVT, default 2, number of event channels (≥1; channel 0 = stall, channel 1 = flush by convention).
- CNT_W, default 32, width of every counter (≥8).
- CYC_LIMIT, default 64, run cycles before DONE; 0 = no limit.
- SEL_W, default 2, width of rd_sel_i; must satisfy 2**SEL_W ≥ NUM_EVT+1.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  level; 1 = count, 0 = pause.
- clear_i  in  1  pulse; zero all counters and overflow flags, return to IDLE.
- evt_i  in  NUM_EVT  event strobes, one bit per channel, sampled each cycle.
- rd_req_i  in  1  read request.
- rd_sel_i  in  SEL_W  0 = cycle counter, k = event channel k-1.
- rd_valid_o  out  1  read data valid.
- rd_data_o  out  CNT_W  read data.
- rd_err_o  out  1  selector out of range (with rd_valid_o).
- cycle_o  out  CNT_W  live cycle counter.
- ovf_o  out  NUM_EVT+1  sticky overflow; bit 0 = cycle counter, bit k = channel k-1.
- done_o  out  1  limit reached; halt request to testbench/core.

## Operation
- Reset values:
  - State IDLE.
  - All counters, ovf_o, rd_valid_o, rd_err_o, rd_data_o and done_o = 0.
- States:
  - IDLE:
    - Go to RUN when start_i=1.
  - RUN:
    - cycle counter +1 every cycle.
    - Each event counter k +1 when evt_i[k]=1.
    - start_i=0 → IDLE. Counters hold.
    - Cycle counter reaching CYC_LIMIT (CYC_LIMIT≠0) → DONE.
  - DONE:
    - Counters frozen.
    - done_o=1.
    - start_i ignored.
    - Leave only via clear_i or rst_i.
- Events in IDLE/DONE are ignored.
- The event on the final RUN cycle (the one that makes cycle = CYC_LIMIT) is counted.
- Priority: rst_i > clear_i > state-machine update. clear_i with start_i=1 goes to IDLE; RUN starts the following cycle.
- Arithmetic:
  - All counters are CNT_W unsigned.
  - Incrementing from all-ones sets the matching ovf_o bit (sticky until clear/reset).
  - Value after overflow: see Configuration.
- Read:
  - Allowed in any state, back-to-back, one request per cycle.
  - rd_data_o returns the selected counter's value as registered before that edge's update (pre-increment, pre-clear).
  - rd_sel_i > NUM_EVT → rd_data_o=0, rd_err_o=1.
  - Cycle without rd_req_i → rd_valid_o=0, rd_err_o=0, rd_data_o holds.

## Timing
- Counter and state updates: 1-cycle latency from the sampling edge. cycle_o and ovf_o are registered outputs.
- done_o asserts in the same cycle the cycle counter shows CYC_LIMIT.
- Read latency is exactly 1 cycle: request on edge N → rd_valid_o high after edge N, for one cycle per request.
- No backpressure. Readers must capture data on the cycle rd_valid_o=1.
- rst_i mid-read: rd_valid_o=0 in the following cycle. The pending request is dropped.

## Configuration
- PIPE_PERF_MON_SATURATE_EN:
  - Defined: counters saturate at all-ones; further increments leave the value unchanged. ovf_o bit still sets.
  - Undefined: counters wrap to 0; ovf_o bit sets.

## Test plan
- Reset, start_i=1 held, evt_i=2'b01 every third cycle, CYC_LIMIT=64:
  - done_o rises when cycle_o=64.
  - Reading sel 1 returns 22, sel 2 returns 0.
  - cycle_o stays 64 for 10 further cycles.
- Pause:
  - RUN 10 cycles, start_i=0 for 5 cycles with evt_i=2'b11, then resume 5 cycles.
  - cycle=15; channels count only RUN-cycle events.
- Read timing:
  - rd_req_i with sel 0 on the same edge as an increment from 7: rd_data_o=7 next cycle, cycle_o=8.
  - sel 3 with NUM_EVT=2: rd_err_o=1, data 0.
- Overflow, CNT_W=8, CYC_LIMIT=0, evt_i[0]=1 for 260 cycles:
  - Without macro: sel 1 reads 4, ovf_o[1]=1.
  - With PIPE_PERF_MON_SATURATE_EN: sel 1 reads 255, ovf_o[1]=1.
- clear_i in DONE with start_i=1:
  - All counters 0, ovf_o=0, done_o=0, state IDLE next cycle, RUN the cycle after.
  - A same-cycle read returns the pre-clear value.
- rst_i asserted mid-RUN with rd_req_i pending: all outputs 0 next cycle, rd_valid_o=0.
